// File: rtl/mrmac_gt_reset_seq_if.sv
// Port bundle of the MRMAC GT reset sequencer: per-port requests/done in,
// per-port GT reset and status out.
interface mrmac_gt_reset_seq_if #(
   parameter int NUM_PORTS = 4,
   parameter int RW        = 2
);
   logic [NUM_PORTS-1:0]    start;
   logic [NUM_PORTS-1:0]    stop;
   logic [NUM_PORTS-1:0]    stat_mst_reset_done;
   logic [NUM_PORTS-1:0]    gt_reset_all_out;
   logic [NUM_PORTS-1:0]    port_ready;
   logic [NUM_PORTS-1:0]    port_fail;
   logic [3*NUM_PORTS-1:0]  port_state;
   logic [RW*NUM_PORTS-1:0] retry_cnt;
   logic [NUM_PORTS-1:0]    link_drop;
   logic [8*NUM_PORTS-1:0]  drop_cnt;
   logic                    busy;

   modport master (
      output start, stop, stat_mst_reset_done,
      input  gt_reset_all_out, port_ready, port_fail, port_state,
             retry_cnt, link_drop, drop_cnt, busy
   );

   modport slave (
      input  start, stop, stat_mst_reset_done,
      output gt_reset_all_out, port_ready, port_fail, port_state,
             retry_cnt, link_drop, drop_cnt, busy
   );
endinterface

// File: rtl/mrmac_gt_reset_seq.sv
// Per-port GT reset/bring-up sequencer: hold GT reset, wait for synchronised
// reset-done, retry on timeout, report ready/fail and link drops.
module mrmac_gt_reset_seq #(
   parameter int NUM_PORTS      = 4,
   parameter int RESET_CYCLES   = 16,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int MAX_RETRY      = 3,
   parameter int SYNC_STAGES    = 2,
   parameter int AUTO_RECOVER   = 1
) (
   input  logic pl_clk,
   input  logic pl_reset,
   mrmac_gt_reset_seq_if.slave bus
);
   localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int CMAX = (RESET_CYCLES > TIMEOUT_CYCLES) ? RESET_CYCLES : TIMEOUT_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0, RST = 3'd1, WAIT = 3'd2, UP = 3'd3, FAIL = 3'd4
   } state_t;

   logic [NUM_PORTS-1:0][2:0]             st_q, st_d;
   logic [NUM_PORTS-1:0][CW-1:0]          cnt_q, cnt_d;
   logic [NUM_PORTS-1:0][RW-1:0]          rty_q, rty_d;
   logic [NUM_PORTS-1:0][7:0]             drop_q;
   logic [NUM_PORTS-1:0][SYNC_STAGES-1:0] sync_q;
   logic [NUM_PORTS-1:0]                  drop_d, done_sync;
   logic [NUM_PORTS-1:0]                  gt_q, rdy_q, fail_q, ldrop_q;
   logic                                  busy_d, busy_q;

   // Next-state per port; stop outranks start, start outranks internal moves.
   always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      rty_d  = rty_q;
      drop_d = '0;
      busy_d = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         done_sync[i] = sync_q[i][SYNC_STAGES-1];
         if (bus.stop[i]) begin
            st_d[i]  = IDLE;
            cnt_d[i] = '0;
         end else begin
            case (st_q[i])
               IDLE, FAIL: if (bus.start[i]) begin
                  st_d[i]  = RST;
                  cnt_d[i] = '0;
                  rty_d[i] = '0;
               end
               RST: if (cnt_q[i] == RST_LAST) begin
                  st_d[i]  = WAIT;
                  cnt_d[i] = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + 1'b1;
               end
               WAIT: if (done_sync[i]) begin
                  st_d[i]  = UP;
                  cnt_d[i] = '0;
               end else if (cnt_q[i] == TMO_LAST) begin
                  cnt_d[i] = '0;
                  if (int'(rty_q[i]) < MAX_RETRY) begin
                     rty_d[i] = rty_q[i] + 1'b1;
                     st_d[i]  = RST;
                  end else begin
                     st_d[i]  = FAIL;
                  end
               end else begin
                  cnt_d[i] = cnt_q[i] + 1'b1;
               end
               // UP is only reached with done_sync high, so a low here is a falling edge.
               UP: if (bus.start[i]) begin
                  st_d[i]  = RST;
                  cnt_d[i] = '0;
                  rty_d[i] = '0;
               end else if (!done_sync[i]) begin
                  drop_d[i] = 1'b1;
                  cnt_d[i]  = '0;
                  if (AUTO_RECOVER != 0) begin
                     st_d[i]  = RST;
                     rty_d[i] = '0;
                  end else begin
                     st_d[i]  = FAIL;
                  end
               end
               default: begin
                  st_d[i]  = IDLE;
                  cnt_d[i] = '0;
               end
            endcase
         end
         if (st_d[i] == RST || st_d[i] == WAIT) busy_d = 1'b1;
      end
   end

   // Status outputs are decoded from next state so they line up with port_state.
   always_ff @(posedge pl_clk) begin
      if (pl_reset) begin
         st_q    <= '0;
         cnt_q   <= '0;
         rty_q   <= '0;
         drop_q  <= '0;
         sync_q  <= '0;
         gt_q    <= '1;
         rdy_q   <= '0;
         fail_q  <= '0;
         ldrop_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         st_q    <= st_d;
         cnt_q   <= cnt_d;
         rty_q   <= rty_d;
         ldrop_q <= drop_d;
         busy_q  <= busy_d;
         for (int i = 0; i < NUM_PORTS; i++) begin
            sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], bus.stat_mst_reset_done[i]};
            gt_q[i]   <= (st_d[i] == IDLE) || (st_d[i] == RST) || (st_d[i] == FAIL);
            rdy_q[i]  <= (st_d[i] == UP);
            fail_q[i] <= (st_d[i] == FAIL);
            if (drop_d[i] && drop_q[i] != 8'hFF) drop_q[i] <= drop_q[i] + 8'd1;
         end
      end
   end

   assign bus.gt_reset_all_out = gt_q;
   assign bus.port_ready       = rdy_q;
   assign bus.port_fail        = fail_q;
   assign bus.port_state       = st_q;
   assign bus.retry_cnt        = rty_q;
   assign bus.link_drop        = ldrop_q;
   assign bus.drop_cnt         = drop_q;
   assign bus.busy             = busy_q;
endmodule

// File: tb/tb_mrmac_gt_reset_seq.sv
// Directed bench: default, no-auto-recover and minimal single-port sequencers
// driven side by side from one clock and reset.
module tb_mrmac_gt_reset_seq;
   logic pl_clk   = 1'b0;
   logic pl_reset = 1'b1;
   int   n_chk    = 0;
   int   n_fail   = 0;
   int   len;

   always #5 pl_clk = ~pl_clk;

   mrmac_gt_reset_seq_if #(.NUM_PORTS(4), .RW(2)) ifa ();
   mrmac_gt_reset_seq_if #(.NUM_PORTS(4), .RW(2)) ifb ();
   mrmac_gt_reset_seq_if #(.NUM_PORTS(1), .RW(1)) ifc ();

   mrmac_gt_reset_seq #(.AUTO_RECOVER(1)) dut_a (
      .pl_clk(pl_clk), .pl_reset(pl_reset), .bus(ifa));
   mrmac_gt_reset_seq #(.AUTO_RECOVER(0)) dut_b (
      .pl_clk(pl_clk), .pl_reset(pl_reset), .bus(ifb));
   mrmac_gt_reset_seq #(.NUM_PORTS(1), .MAX_RETRY(0), .RESET_CYCLES(1),
                        .TIMEOUT_CYCLES(8)) dut_c (
      .pl_clk(pl_clk), .pl_reset(pl_reset), .bus(ifc));

   task automatic tick();
      @(posedge pl_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      ifa.start = '0; ifa.stop = '0; ifa.stat_mst_reset_done = '0;
      ifb.start = '0; ifb.stop = '0; ifb.stat_mst_reset_done = '0;
      ifc.start = '0; ifc.stop = '0; ifc.stat_mst_reset_done = '0;

      // reset state
      tick(); tick();
      chk("rst_state", 32'(ifa.port_state), 32'h0);
      chk("rst_gt", 32'(ifa.gt_reset_all_out), 32'hf);
      chk("rst_ready", 32'(ifa.port_ready), 32'h0);
      chk("rst_fail", 32'(ifa.port_fail), 32'h0);
      chk("rst_busy", 32'(ifa.busy), 32'h0);
      chk("rst_retry", 32'(ifa.retry_cnt), 32'h0);
      chk("rst_drop", 32'(ifa.drop_cnt), 32'h0);
      chk("rst_c_gt", 32'(ifc.gt_reset_all_out), 32'h1);
      pl_reset = 1'b0;
      tick();

      // port 0 bring-up
      ifa.start[0] = 1'b1; tick(); ifa.start[0] = 1'b0;
      chk("t1_rst_entry", 32'(ifa.port_state[2:0]), 32'd1);
      chk("t1_busy", 32'(ifa.busy), 32'd1);
      len = 1;
      tick();
      while (ifa.port_state[2:0] == 3'd1 && len < 40) begin
         len++;
         tick();
      end
      chk("t1_rst_len", 32'(len), 32'd16);
      chk("t1_wait", 32'(ifa.port_state[2:0]), 32'd2);
      chk("t1_gt_low", 32'(ifa.gt_reset_all_out[0]), 32'd0);
      repeat (50) tick();
      chk("t1_still_wait", 32'(ifa.port_state[2:0]), 32'd2);
      ifa.stat_mst_reset_done[0] = 1'b1;
      tick(); tick();
      chk("t1_ready_early", 32'(ifa.port_ready[0]), 32'd0);
      tick();
      chk("t1_ready", 32'(ifa.port_ready[0]), 32'd1);
      chk("t1_up", 32'(ifa.port_state[2:0]), 32'd3);
      chk("t1_retry", 32'(ifa.retry_cnt[1:0]), 32'd0);
      chk("t1_others_idle", 32'(ifa.port_state[11:3]), 32'd0);
      chk("t1_others_gt", 32'(ifa.gt_reset_all_out), 32'he);

      // port 1 exhausts retries; port 3 gets done in the last timeout cycle
      ifa.start[1] = 1'b1; ifa.start[3] = 1'b1;
      for (int n = 1; n <= 4161; n++) begin
         tick();
         if (n == 1) begin ifa.start[1] = 1'b0; ifa.start[3] = 1'b0; end
         if (n == 4158) ifa.stat_mst_reset_done[3] = 1'b1;
         if (n == 1040) begin
            chk("t2_wait_a0", 32'(ifa.port_state[5:3]), 32'd2);
            chk("t2_retry_a0", 32'(ifa.retry_cnt[3:2]), 32'd0);
         end
         if (n == 1041) begin
            chk("t2_rst_a1", 32'(ifa.port_state[5:3]), 32'd1);
            chk("t2_retry_a1", 32'(ifa.retry_cnt[3:2]), 32'd1);
         end
         if (n == 3121) begin
            chk("t2_retry_a3", 32'(ifa.retry_cnt[3:2]), 32'd3);
            chk("t4_retry_a3", 32'(ifa.retry_cnt[7:6]), 32'd3);
         end
         if (n == 4160) begin
            chk("t2_last_wait", 32'(ifa.port_state[5:3]), 32'd2);
            chk("t4_last_wait", 32'(ifa.port_state[11:9]), 32'd2);
         end
      end
      chk("t2_fail_state", 32'(ifa.port_state[5:3]), 32'd4);
      chk("t2_fail", 32'(ifa.port_fail[1]), 32'd1);
      chk("t2_fail_gt", 32'(ifa.gt_reset_all_out[1]), 32'd1);
      chk("t2_fail_retry", 32'(ifa.retry_cnt[3:2]), 32'd3);
      chk("t4_up", 32'(ifa.port_state[11:9]), 32'd3);
      chk("t4_ready", 32'(ifa.port_ready[3]), 32'd1);
      chk("t4_not_fail", 32'(ifa.port_fail[3]), 32'd0);
      ifa.start[1] = 1'b1; tick(); ifa.start[1] = 1'b0;
      chk("t2_restart", 32'(ifa.port_state[5:3]), 32'd1);
      chk("t2_restart_retry", 32'(ifa.retry_cnt[3:2]), 32'd0);
      chk("t2_restart_fail", 32'(ifa.port_fail[1]), 32'd0);
      ifa.stop[1] = 1'b1; tick(); ifa.stop[1] = 1'b0;
      chk("t2_stop", 32'(ifa.port_state[5:3]), 32'd0);

      // port 2 link drop, auto-recover vs fail
      ifa.stat_mst_reset_done[2] = 1'b1; ifb.stat_mst_reset_done[2] = 1'b1;
      tick(); tick(); tick();
      ifa.start[2] = 1'b1; ifb.start[2] = 1'b1;
      tick();
      ifa.start[2] = 1'b0; ifb.start[2] = 1'b0;
      repeat (17) tick();
      chk("t3_a_ready", 32'(ifa.port_ready[2]), 32'd1);
      chk("t3_b_ready", 32'(ifb.port_ready[2]), 32'd1);
      ifa.stat_mst_reset_done[2] = 1'b0; ifb.stat_mst_reset_done[2] = 1'b0;
      tick(); tick();
      chk("t3_no_drop_yet", 32'(ifa.link_drop[2]), 32'd0);
      tick();
      chk("t3_a_drop", 32'(ifa.link_drop[2]), 32'd1);
      chk("t3_b_drop", 32'(ifb.link_drop[2]), 32'd1);
      chk("t3_a_cnt", 32'(ifa.drop_cnt[23:16]), 32'd1);
      chk("t3_b_cnt", 32'(ifb.drop_cnt[23:16]), 32'd1);
      chk("t3_a_rst", 32'(ifa.port_state[8:6]), 32'd1);
      chk("t3_b_fail", 32'(ifb.port_state[8:6]), 32'd4);
      chk("t3_b_fail_flag", 32'(ifb.port_fail[2]), 32'd1);
      tick();
      chk("t3_pulse_once", 32'(ifa.link_drop[2]), 32'd0);
      repeat (6) tick();
      ifa.stat_mst_reset_done[2] = 1'b1; ifb.stat_mst_reset_done[2] = 1'b1;
      repeat (30) tick();
      chk("t3_a_recovered", 32'(ifa.port_ready[2]), 32'd1);
      chk("t3_a_cnt_hold", 32'(ifa.drop_cnt[23:16]), 32'd1);
      chk("t3_b_held", 32'(ifb.port_state[8:6]), 32'd4);
      chk("t3_b_gt", 32'(ifb.gt_reset_all_out[2]), 32'd1);

      // stop beats start in WAIT
      ifa.stat_mst_reset_done[0] = 1'b0;
      ifa.start[0] = 1'b1; tick(); ifa.start[0] = 1'b0;
      chk("t5_forced_rst", 32'(ifa.port_state[2:0]), 32'd1);
      repeat (18) tick();
      chk("t5_in_wait", 32'(ifa.port_state[2:0]), 32'd2);
      chk("t5_no_drop", 32'(ifa.drop_cnt[7:0]), 32'd0);
      ifa.start[0] = 1'b1; ifa.stop[0] = 1'b1;
      tick();
      ifa.start[0] = 1'b0; ifa.stop[0] = 1'b0;
      chk("t5_stop_idle", 32'(ifa.port_state[2:0]), 32'd0);
      chk("t5_stop_gt", 32'(ifa.gt_reset_all_out[0]), 32'd1);
      chk("t5_busy_idle", 32'(ifa.busy), 32'd0);

      // reset mid-sequence
      ifa.start = 4'hf; tick(); ifa.start = 4'h0;
      repeat (4) tick();
      chk("t5_all_rst", 32'(ifa.port_state), 32'h249);
      chk("t5_busy", 32'(ifa.busy), 32'd1);
      pl_reset = 1'b1; tick();
      chk("t5_reset_state", 32'(ifa.port_state), 32'h0);
      chk("t5_reset_busy", 32'(ifa.busy), 32'd0);
      chk("t5_reset_gt", 32'(ifa.gt_reset_all_out), 32'hf);
      chk("t5_reset_drop", 32'(ifa.drop_cnt), 32'h0);
      pl_reset = 1'b0; tick();

      // minimal config: 1-cycle reset, no retries
      ifc.start[0] = 1'b1; tick(); ifc.start[0] = 1'b0;
      chk("t6_rst", 32'(ifc.port_state), 32'd1);
      chk("t6_gt_high", 32'(ifc.gt_reset_all_out), 32'd1);
      tick();
      chk("t6_wait", 32'(ifc.port_state), 32'd2);
      chk("t6_gt_low", 32'(ifc.gt_reset_all_out), 32'd0);
      repeat (7) tick();
      chk("t6_last_wait", 32'(ifc.port_state), 32'd2);
      tick();
      chk("t6_fail", 32'(ifc.port_state), 32'd4);
      chk("t6_fail_flag", 32'(ifc.port_fail), 32'd1);
      chk("t6_retry", 32'(ifc.retry_cnt), 32'd0);
      chk("t6_fail_gt", 32'(ifc.gt_reset_all_out), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
